fm_modulate: RTL and testbench

FM_MODULATE -- requirements
Module: fm_modulate

---
 rtl/fm_modulate.sv | 113 +++++++++++
 tb/tb_fm_modulate.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_modulate.sv
// FM modulator: integrates audio samples into a 32-bit phase and emits one
// quantized cos/sin (I/Q) pair per sample through a registered sine ROM.
module fm_modulate #(
  parameter int QUANT_BITS = 10,
  parameter int PHASE_GAIN = 1024
) (
  input  logic               clock,
  input  logic               reset,
  output logic               in_rd_en,
  input  logic               in_empty,
  input  logic signed [31:0] in_dout,
  output logic               real_wr_en,
  input  logic               real_full,
  output logic signed [31:0] real_din,
  output logic               imag_wr_en,
  input  logic               imag_full,
  output logic signed [31:0] imag_din
);

  // state    | meaning
  // S_READ   | wait for a sample, pop it and advance the phase
  // S_LOOKUP | register sin/cos ROM outputs for the new phase
  // S_WRITE  | push the I/Q pair once both output FIFOs have room
  typedef enum logic [1:0] {
    S_READ   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 2.0 ** QUANT_BITS;
  localparam logic signed [63:0] GAIN64     = 64'(PHASE_GAIN);
  localparam logic signed [63:0] TRUNC_BIAS = (64'sd1 <<< QUANT_BITS) - 64'sd1;

  state_t             state_q, state_d;
  logic        [31:0] phase_q, phase_d;
  logic signed [31:0] sin_q, sin_d;
  logic signed [31:0] cos_q, cos_d;

  logic signed [31:0] sin_rom [1024];
  logic        [9:0]  sin_addr;
  logic        [9:0]  cos_addr;
  logic signed [63:0] product;
  logic        [31:0] inc;

  // Table is folded to constants at elaboration; rounding is half away from zero.
  for (genvar k = 0; k < 1024; k++) begin : g_rom
    localparam real X = SCALE * $sin(2.0 * PI * k / 1024.0);
    localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
    assign sin_rom[k] = V;
  end

  assign sin_addr = phase_q[31:22];
  assign cos_addr = sin_addr + 10'd256;

  // Biasing negative products before the shift makes the divide truncate toward zero.
  assign product = GAIN64 * 64'(in_dout);
  assign inc     = 32'((product + (product[63] ? TRUNC_BIAS : 64'sd0)) >>> QUANT_BITS);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    sin_d      = sin_q;
    cos_d      = cos_q;
    in_rd_en   = 1'b0;
    real_wr_en = 1'b0;
    imag_wr_en = 1'b0;
    real_din   = '0;
    imag_din   = '0;
    case (state_q)
      S_READ: begin
        if (!in_empty && !reset) begin
          in_rd_en = 1'b1;
          phase_d  = phase_q + inc;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        sin_d   = sin_rom[sin_addr];
        cos_d   = sin_rom[cos_addr];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!real_full && !imag_full) begin
          real_wr_en = 1'b1;
          imag_wr_en = 1'b1;
          real_din   = cos_q;
          imag_din   = sin_q;
          state_d    = S_READ;
        end
      end
      default: begin
        state_d = S_READ;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      phase_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

endmodule

// File: tb/tb_fm_modulate.sv
// Bench for fm_modulate: directed vector table, stall/reset sequences and
// randomized samples checked against a phase/trig reference model.
module tb_fm_modulate;

  localparam int  QB = 10;
  localparam real PI = 3.14159265358979323846;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_rd_en;
  logic               in_empty;
  logic signed [31:0] in_dout;
  logic               real_wr_en;
  logic               real_full;
  logic signed [31:0] real_din;
  logic               imag_wr_en;
  logic               imag_full;
  logic signed [31:0] imag_din;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  int unsigned model_phase;

  typedef struct {
    bit          do_reset;
    logic [31:0] sample;
    int          exp_real;
    int          exp_imag;
  } vec_t;

  vec_t vecs[9];

  fm_modulate dut (
    .clock      (clock),
    .reset      (reset),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .real_wr_en (real_wr_en),
    .real_full  (real_full),
    .real_din   (real_din),
    .imag_wr_en (imag_wr_en),
    .imag_full  (imag_full),
    .imag_din   (imag_din)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: amplitude of a unit phasor quantized to QB fraction bits.
  function automatic int q_round(input real x);
    return (x >= 0.0) ? $rtoi($floor(x + 0.5)) : -$rtoi($floor(-x + 0.5));
  endfunction

  function automatic int model_sin(input int unsigned ph);
    int unsigned a = ph >> 22;
    return q_round((2.0 ** QB) * $sin(2.0 * PI * a / 1024.0));
  endfunction

  function automatic int model_cos(input int unsigned ph);
    int unsigned a = ph >> 22;
    return q_round((2.0 ** QB) * $cos(2.0 * PI * a / 1024.0));
  endfunction

  function automatic int unsigned model_inc(input int s);
    longint p = longint'(1024) * longint'(s);
    longint q = p / (longint'(1) << QB);
    return int'(q);
  endfunction

  // Invariants that must hold on every cycle.
  always @(negedge clock) begin
    #2;
    if (mon_en) begin
      check("pair_wr_en", real_wr_en, imag_wr_en);
      if (!real_wr_en) check("real_din_idle", real_din, 0);
      if (!imag_wr_en) check("imag_din_idle", imag_din, 0);
      if (in_empty)    check("rd_while_empty", in_rd_en, 0);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_phase = 0;
  endtask

  task automatic wait_pop(output bit got);
    int cyc = 0;
    #1;
    while (!in_rd_en && cyc < 30) begin
      @(negedge clock);
      #1;
      cyc++;
    end
    got = in_rd_en;
    check("pop_seen", got, 1);
  endtask

  task automatic push_check(input logic [31:0] s, input int er, input int ei,
                            input bit rand_stall, input bit exact_lat);
    bit got;
    int lat = 0;
    in_dout  = s;
    in_empty = 1'b0;
    wait_pop(got);
    if (!got) begin
      in_empty = 1'b1;
      return;
    end
    @(posedge clock);
    #1;
    in_empty = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      if (rand_stall) begin
        real_full = ($urandom_range(0, 2) == 0);
        imag_full = ($urandom_range(0, 2) == 0);
      end
      #1;
    end while (!real_wr_en && lat < 60);
    check("write_seen", real_wr_en, 1);
    if (exact_lat) check("latency", lat, 2);
    else if (lat < 2) check("min_latency", lat, 2);
    check("imag_wr_pair", imag_wr_en, 1);
    check("real_din", real_din, er);
    check("imag_din", imag_din, ei);
    @(posedge clock);
    #1;
    real_full = 1'b0;
    imag_full = 1'b0;
    @(negedge clock);
    #1;
    check("single_write", real_wr_en, 0);
  endtask

  initial begin
    bit got;
    logic [31:0] s;

    vecs[0] = '{1'b1, 32'h4000_0000,     0,  1024};
    vecs[1] = '{1'b0, 32'h4000_0000, -1024,     0};
    vecs[2] = '{1'b0, 32'h4000_0000,     0, -1024};
    vecs[3] = '{1'b0, 32'h4000_0000,  1024,     0};
    vecs[4] = '{1'b0, 32'h2000_0000,   724,   724};
    vecs[5] = '{1'b1, 32'hC000_0000,     0, -1024};
    vecs[6] = '{1'b1, 32'h0000_0000,  1024,     0};
    vecs[7] = '{1'b1, 32'h0000_0001,  1024,     0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF,  1024,    -6};

    // Reset state, with a sample waiting so a pop during reset would show.
    reset     = 1'b1;
    in_empty  = 1'b0;
    in_dout   = 32'h4000_0000;
    real_full = 1'b0;
    imag_full = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_real_wr_en", real_wr_en, 0);
    check("rst_imag_wr_en", imag_wr_en, 0);
    check("rst_real_din", real_din, 0);
    check("rst_imag_din", imag_din, 0);
    in_empty = 1'b1;
    reset    = 1'b0;
    mon_en   = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_reset) do_reset();
      push_check(vecs[i].sample, vecs[i].exp_real, vecs[i].exp_imag, 1'b0, 1'b1);
    end

    // Real FIFO full: the pair is held, nothing else pops, then one paired write.
    do_reset();
    real_full = 1'b1;
    in_dout   = 32'h4000_0000;
    in_empty  = 1'b0;
    wait_pop(got);
    @(posedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check("stall_real_wr", real_wr_en, 0);
      check("stall_imag_wr", imag_wr_en, 0);
      check("stall_rd", in_rd_en, 0);
    end
    @(negedge clock);
    real_full = 1'b0;
    in_empty  = 1'b1;
    #1;
    check("release_real_wr", real_wr_en, 1);
    check("release_imag_wr", imag_wr_en, 1);
    check("release_real", real_din, 0);
    check("release_imag", imag_din, 1024);
    @(negedge clock);
    #1;
    check("release_single", real_wr_en, 0);

    // Reset while stalled on imag_full discards the pending pair.
    do_reset();
    imag_full = 1'b1;
    in_dout   = 32'h4000_0000;
    in_empty  = 1'b0;
    wait_pop(got);
    @(posedge clock);
    repeat (3) @(negedge clock);
    #1;
    check("imag_stall_wr", real_wr_en, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_rd", in_rd_en, 0);
    check("mid_rst_real_wr", real_wr_en, 0);
    check("mid_rst_imag_wr", imag_wr_en, 0);
    check("mid_rst_real_din", real_din, 0);
    check("mid_rst_imag_din", imag_din, 0);
    imag_full = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_phase = 0;
    push_check(32'h4000_0000, 0, 1024, 1'b0, 1'b1);

    // Randomized samples with random back-pressure against the model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) s = $urandom;
      else s = 32'($signed($urandom_range(0, 1 << 22)) - (1 << 21));
      model_phase += model_inc(s);
      push_check(s, model_cos(model_phase), model_sin(model_phase), 1'b1, 1'b0);
    end

    // Idle input: nothing moves and the phase is kept.
    in_empty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      check("idle_rd", in_rd_en, 0);
      check("idle_wr", real_wr_en | imag_wr_en, 0);
    end
    push_check(32'h0, model_cos(model_phase), model_sin(model_phase), 1'b0, 1'b1);

    mon_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
